led_blink_array: RTL and testbench

- Parametrised multi-channel LED driver and successor to the single fixed-rate blinker.
- Each channel independently runs OFF, ON, BLINK (programmable on/off lengths) or BURST (N blinks, then self-stop with done pulse).
- Sits between the board-level control logic and the LED pins, with a simple per-channel register-write config port.
- One clock domain throughout.

---
 rtl/led_blink_array.sv | 153 +++++++++++++++
 tb/tb_led_blink_array.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_array.sv
// Multi-channel LED driver: each channel runs OFF, ON, BLINK or a counted BURST,
// reprogrammed through a per-channel register-write port. Single clock domain.
module led_blink_array #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int BURST_W  = 8,
    parameter int RST_HALF = 25000,
    parameter int RST_MODE = 2,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [CNT_W-1:0]   cfg_on,
    input  logic [CNT_W-1:0]   cfg_off,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic [N_CH-1:0]    led,
    output logic [N_CH-1:0]    busy,
    output logic [N_CH-1:0]    done
);

    typedef enum logic [1:0] {MODE_OFF = 2'd0, MODE_ON = 2'd1, MODE_BLINK = 2'd2, MODE_BURST = 2'd3} mode_e;
    typedef enum logic {PH_OFF = 1'b0, PH_ON = 1'b1} phase_e;

    localparam logic [CNT_W-1:0] RST_LEN = (RST_HALF == 0) ? CNT_W'(1) : CNT_W'(RST_HALF);
    localparam mode_e RST_MODE_E = mode_e'(2'(RST_MODE));

    // A zero length would make a phase vanish, so it is stored as one cycle.
    function automatic logic [CNT_W-1:0] fix_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    mode_e              mode_q       [N_CH];
    mode_e              mode_d       [N_CH];
    phase_e             phase_q      [N_CH];
    phase_e             phase_d      [N_CH];
    logic [CNT_W-1:0]   on_len_q     [N_CH];
    logic [CNT_W-1:0]   on_len_d     [N_CH];
    logic [CNT_W-1:0]   off_len_q    [N_CH];
    logic [CNT_W-1:0]   off_len_d    [N_CH];
    logic [CNT_W-1:0]   count_q      [N_CH];
    logic [CNT_W-1:0]   count_d      [N_CH];
    logic [BURST_W-1:0] burst_left_q [N_CH];
    logic [BURST_W-1:0] burst_left_d [N_CH];
    logic [N_CH-1:0]    led_q, led_d;
    logic [N_CH-1:0]    busy_q, busy_d;
    logic [N_CH-1:0]    done_q, done_d;
    logic [N_CH-1:0]    wr_hit;
    logic [N_CH-1:0]    phase_end;

    // An out-of-range cfg_ch matches no channel, so such a write is simply dropped.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i]    = cfg_we && (int'(cfg_ch) == i);
            phase_end[i] = (count_q[i] == ((phase_q[i] == PH_ON) ? on_len_q[i] : off_len_q[i]));
        end
    end

    always_comb begin
        // NOTE: every _d starts from its held value, so no branch below can infer a latch.
        mode_d       = mode_q;
        phase_d      = phase_q;
        on_len_d     = on_len_q;
        off_len_d    = off_len_q;
        count_d      = count_q;
        burst_left_d = burst_left_q;
        led_d        = led_q;
        busy_d       = busy_q;
        done_d       = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_hit[i]) begin
                mode_d[i]       = mode_e'(cfg_mode);
                on_len_d[i]     = fix_len(cfg_on);
                off_len_d[i]    = fix_len(cfg_off);
                burst_left_d[i] = cfg_burst;
                phase_d[i]      = PH_ON;
                count_d[i]      = CNT_W'(1);
                busy_d[i]       = 1'b0;
                unique case (mode_e'(cfg_mode))
                    MODE_OFF:              led_d[i] = 1'b0;
                    MODE_ON, MODE_BLINK:   led_d[i] = 1'b1;
                    MODE_BURST: begin
                        if (cfg_burst != '0) begin
                            led_d[i]  = 1'b1;
                            busy_d[i] = 1'b1;
                        end else begin
                            mode_d[i] = MODE_OFF;
                            led_d[i]  = 1'b0;
                            done_d[i] = 1'b1;
                        end
                    end
                endcase
            end else if (en && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BURST)) begin
                if (!phase_end[i]) begin
                    count_d[i] = count_q[i] + CNT_W'(1);
                end else begin
                    count_d[i] = CNT_W'(1);
                    if (mode_q[i] == MODE_BURST && phase_q[i] == PH_ON &&
                        burst_left_q[i] == BURST_W'(1)) begin
                        // Last ON phase of a burst: stop immediately, no trailing OFF phase.
                        mode_d[i]       = MODE_OFF;
                        phase_d[i]      = PH_OFF;
                        burst_left_d[i] = '0;
                        led_d[i]        = 1'b0;
                        busy_d[i]       = 1'b0;
                        done_d[i]       = 1'b1;
                    end else begin
                        if (mode_q[i] == MODE_BURST && phase_q[i] == PH_ON)
                            burst_left_d[i] = burst_left_q[i] - BURST_W'(1);
                        phase_d[i] = (phase_q[i] == PH_ON) ? PH_OFF : PH_ON;
                        led_d[i]   = (phase_q[i] == PH_OFF);
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all channels update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-channel arrays are plain flops, not RAM, so each entry is reset explicitly.
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i]       <= RST_MODE_E;
                phase_q[i]      <= PH_OFF;
                on_len_q[i]     <= RST_LEN;
                off_len_q[i]    <= RST_LEN;
                count_q[i]      <= CNT_W'(1);
                burst_left_q[i] <= '0;
            end
            led_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            on_len_q     <= on_len_d;
            off_len_q    <= off_len_d;
            count_q      <= count_d;
            burst_left_q <= burst_left_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_blink_array.sv
// Scoreboard bench for led_blink_array: a cycle-indexed pattern model pushes expected
// outputs per edge; a monitor pops and compares on the falling edge.
module tb_led_blink_array;

    localparam int N_CH     = 3;
    localparam int CNT_W    = 16;
    localparam int BURST_W  = 8;
    localparam int RST_HALF = 3;
    localparam int RST_MODE = 2;
    localparam int CH_W     = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [1:0]         cfg_mode;
    logic [CNT_W-1:0]   cfg_on;
    logic [CNT_W-1:0]   cfg_off;
    logic [BURST_W-1:0] cfg_burst;
    logic [N_CH-1:0]    led;
    logic [N_CH-1:0]    busy;
    logic [N_CH-1:0]    done;

    led_blink_array #(
        .N_CH(N_CH), .CNT_W(CNT_W), .BURST_W(BURST_W),
        .RST_HALF(RST_HALF), .RST_MODE(RST_MODE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_burst(cfg_burst),
        .led(led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH-1:0] led;
        logic [N_CH-1:0] busy;
        logic [N_CH-1:0] done;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a pattern indexed by enabled cycles since its last restart.
    int m_mode  [N_CH];
    int m_on    [N_CH];
    int m_off   [N_CH];
    int m_burst [N_CH];
    int m_t     [N_CH];
    int m_ph0   [N_CH];
    bit m_done  [N_CH];

    function automatic int fix(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c]  = RST_MODE;
            m_on[c]    = fix(RST_HALF);
            m_off[c]   = fix(RST_HALF);
            m_burst[c] = 0;
            m_t[c]     = 0;
            m_ph0[c]   = m_on[c];   // reset starts at the beginning of the OFF phase
            m_done[c]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N_CH; c++) begin
            m_done[c] = 1'b0;
            if (cfg_we && int'(cfg_ch) == c) begin
                m_mode[c]  = int'(cfg_mode);
                m_on[c]    = fix(int'(cfg_on));
                m_off[c]   = fix(int'(cfg_off));
                m_burst[c] = int'(cfg_burst);
                m_t[c]     = 0;
                m_ph0[c]   = 0;
                if (m_mode[c] == 3 && m_burst[c] == 0) begin
                    m_mode[c] = 0;
                    m_done[c] = 1'b1;
                end
            end else if (en) begin
                if (m_mode[c] == 2) m_t[c]++;
                if (m_mode[c] == 3) begin
                    m_t[c]++;
                    if (m_t[c] == m_burst[c] * (m_on[c] + m_off[c]) - m_off[c]) begin
                        m_mode[c] = 0;
                        m_done[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o = '0;
        for (int c = 0; c < N_CH; c++) begin
            o.done[c] = m_done[c];
            case (m_mode[c])
                1: o.led[c] = 1'b1;
                2: o.led[c] = ((m_t[c] + m_ph0[c]) % (m_on[c] + m_off[c])) < m_on[c];
                3: begin
                    o.led[c]  = (m_t[c] % (m_on[c] + m_off[c])) < m_on[c];
                    o.busy[c] = 1'b1;
                end
                default: o.led[c] = 1'b0;
            endcase
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic write(input int ch, input int mode, input int on, input int off, input int burst);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_mode  = 2'(mode);
        cfg_on    = CNT_W'(on);
        cfg_off   = CNT_W'(off);
        cfg_burst = BURST_W'(burst);
        tick();
        cfg_we = 1'b0;
    endtask

    // Monitor: outputs are registered, so one expected entry per rising edge.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("led",  32'(led),  32'(e.led));
                check("busy", 32'(busy), 32'(e.busy));
                check("done", 32'(done), 32'(e.done));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_on = '0; cfg_off = '0; cfg_burst = '0;
        model_reset();
        idle(2);
        @(negedge clk); #2;
        rst_n = 1'b1;
        en    = 1'b1;

        // Reset pattern in lock-step on every channel: low 3, high 3, low 3.
        idle(10);
        // Ch1 blink 2/5 over four periods.
        write(1, 2, 2, 5, 0);
        idle(28);
        // Ch0 burst 1/2 x3, then idle past completion.
        write(0, 3, 1, 2, 3);
        idle(10);
        // En freeze in the middle of the ON phase of a 4/4 blink.
        write(1, 2, 4, 4, 0);
        idle(2);
        en = 1'b0;
        idle(10);
        en = 1'b1;
        idle(8);
        // Write ON to ch2 exactly on its phase-end edge.
        write(2, 2, 3, 3, 0);
        idle(2);
        write(2, 1, 0, 0, 0);
        idle(4);
        // Burst with count zero: done pulse only.
        write(1, 3, 3, 3, 0);
        idle(3);
        // Out-of-range channel: nothing changes.
        write(3, 3, 1, 1, 2);
        idle(5);
        // Asynchronous reset in the middle of a burst.
        write(0, 3, 2, 2, 4);
        idle(3);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_led",  32'(led),  32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        tick();
        @(negedge clk); #2;
        rst_n = 1'b1;
        idle(10);

        // Randomised traffic, including zero lengths, zero bursts, bad channels and en gaps.
        for (int k = 0; k < 400; k++) begin
            en        = ($urandom_range(0, 9) != 0);
            cfg_we    = ($urandom_range(0, 4) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 3));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_on    = CNT_W'($urandom_range(0, 5));
            cfg_off   = CNT_W'($urandom_range(0, 5));
            cfg_burst = BURST_W'($urandom_range(0, 4));
            tick();
        end
        cfg_we = 1'b0;
        en     = 1'b1;
        idle(5);

        @(negedge clk); #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
